// File: rtl/mac_pkg.sv
// Shared widths, FSM encoding and saturation constant for the MAC job sequencer.
// Optional build macro MAC_SATURATE_EN is consumed in mac_pipe.sv.
package mac_pkg;

    localparam int unsigned OP_W  = 8;
    localparam int unsigned ACC_W = 16;
    localparam int unsigned LEN_W = 8;

    localparam logic [ACC_W-1:0] ACC_SAT = {ACC_W{1'b1}};

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StLoad  = 2'd1;
    localparam state_t StDrain = 2'd2;
    localparam state_t StDone  = 2'd3;

endpackage

// File: rtl/mac_job_sequencer_if.sv
// Job request, operand handshake and result bundle between a job source and the sequencer.
interface mac_job_if
    import mac_pkg::*;
#(
    parameter int unsigned OpW  = OP_W,
    parameter int unsigned AccW = ACC_W,
    parameter int unsigned LenW = LEN_W
) ();

    logic            start;
    logic [LenW-1:0] len;
    logic            in_valid;
    logic            in_ready;
    logic [OpW-1:0]  b;
    logic [OpW-1:0]  c;
    logic [AccW-1:0] acc;
    logic            overflow;
    logic            busy;
    logic            done;

    modport master (
        output start, len, in_valid, b, c,
        input  in_ready, acc, overflow, busy, done
    );

    modport slave (
        input  start, len, in_valid, b, c,
        output in_ready, acc, overflow, busy, done
    );

endinterface

// File: rtl/mac_pipe.sv
// Two-stage multiply/accumulate: registered product, then accumulate with sticky overflow.
// MAC_SATURATE_EN selects all-ones saturation on overflow instead of forcing zero.
module mac_pipe
    import mac_pkg::*;
#(
    parameter int unsigned OpW  = OP_W,
    parameter int unsigned AccW = ACC_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            in_fire_i,
    input  logic [OpW-1:0]  b_i,
    input  logic [OpW-1:0]  c_i,
    output logic [AccW-1:0] acc_o,
    output logic            overflow_o,
    output logic            pipe_empty_o
);

    logic [2*OpW-1:0] prod_q;
    logic             vld_q;
    logic [AccW-1:0]  acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [AccW:0]    sum;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= in_fire_i;
            if (in_fire_i) begin
                prod_q <= (2*OpW)'(b_i) * (2*OpW)'(c_i);
            end
        end
    end

    assign sum = {1'b0, acc_q} + (AccW+1)'(prod_q);

    // Once overflowed, products are dropped so acc holds its forced value.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clear_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (vld_q && !ovf_q) begin
            if (sum[AccW]) begin
                ovf_d = 1'b1;
`ifdef MAC_SATURATE_EN
                acc_d = AccW'(ACC_SAT);
`else
                acc_d = '0;
`endif
            end else begin
                acc_d = sum[AccW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_o        = acc_q;
    assign overflow_o   = ovf_q;
    assign pipe_empty_o = !vld_q;

endmodule

// File: rtl/mac_job_sequencer.sv
// Job FSM, length counter and operand handshake driving the shared MAC pipeline.
// Build option MAC_SATURATE_EN (see mac_pipe) changes overflow behaviour.
module mac_job_sequencer
    import mac_pkg::*;
#(
    parameter int unsigned OpW  = OP_W,
    parameter int unsigned AccW = ACC_W,
    parameter int unsigned LenW = LEN_W
) (
    input logic      clk_i,
    input logic      rst_i,
    mac_job_if.slave job_io
);

    state_t          state_q, state_d;
    logic [LenW-1:0] rem_q, rem_d;
    logic            start_acc;
    logic            fire;
    logic            pipe_empty;

    assign start_acc = (state_q == StIdle) && job_io.start;
    assign fire      = job_io.in_valid && job_io.in_ready;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        unique case (state_q)
            StIdle: begin
                if (job_io.start) begin
                    if (job_io.len != '0) begin
                        rem_d   = job_io.len;
                        state_d = StLoad;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StLoad: begin
                if (fire) begin
                    rem_d = rem_q - LenW'(1);
                    if (rem_q == LenW'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pipe_empty) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    assign job_io.in_ready = (state_q == StLoad) && (rem_q != '0);
    assign job_io.busy     = (state_q != StIdle);
    assign job_io.done     = (state_q == StDone);

    mac_pipe #(
        .OpW  (OpW),
        .AccW (AccW)
    ) u_pipe (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (start_acc),
        .in_fire_i    (fire),
        .b_i          (job_io.b),
        .c_i          (job_io.c),
        .acc_o        (job_io.acc),
        .overflow_o   (job_io.overflow),
        .pipe_empty_o (pipe_empty)
    );

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed self-checking bench for mac_job_sequencer; expectations are hand-computed.
module tb_mac_job_sequencer;
    import mac_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mac_job_if job_if ();

    mac_job_sequencer dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .job_io (job_if.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] pb [4];
    logic [7:0] pc [4];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with the sequencer idle; returns at posedge+1 after the start edge.
    task automatic start_job(input logic [7:0] n);
        job_if.start = 1'b1;
        job_if.len   = n;
        @(posedge clk);
        #1;
        job_if.start = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] bv, input logic [7:0] cv, output bit ok);
        job_if.b        = bv;
        job_if.c        = cv;
        job_if.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (job_if.in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        job_if.in_valid = 1'b0;
    endtask

    task automatic feed(input int cnt, input int max_gap, output int accepted);
        bit ok;
        int gap;
        accepted = 0;
        for (int i = 0; i < cnt; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            send_pair(pb[i], pc[i], ok);
            if (ok) accepted++;
        end
    endtask

    // Waits for done, checks result, pulse width and return to idle; ends at posedge+1.
    task automatic finish_job(input string tag, input logic [15:0] exp_acc, input logic exp_ovf,
                              output int done_cnt);
        bit got = 1'b0;
        bit seen_ready = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (job_if.in_ready) seen_ready = 1'b1;
            if (job_if.done) got = 1'b1;
        end
        check_eq({tag, "_done_seen"}, 32'(got), 32'd1);
        if (got) done_cnt = 1;
        check_eq({tag, "_acc"}, 32'(job_if.acc), 32'(exp_acc));
        check_eq({tag, "_ovf"}, 32'(job_if.overflow), 32'(exp_ovf));
        check_eq({tag, "_no_ready_after_last"}, 32'(seen_ready), 32'd0);
        @(negedge clk);
        check_eq({tag, "_done_one_cycle"}, 32'(job_if.done), 32'd0);
        check_eq({tag, "_busy_low_after"}, 32'(job_if.busy), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (job_if.done) done_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int accepted;
        int dcnt;
        bit ok;

        rst             = 1'b1;
        job_if.start    = 1'b0;
        job_if.len      = '0;
        job_if.in_valid = 1'b0;
        job_if.b        = '0;
        job_if.c        = '0;
        #2;
        check_eq("rst_acc", 32'(job_if.acc), 32'd0);
        check_eq("rst_ovf", 32'(job_if.overflow), 32'd0);
        check_eq("rst_busy", 32'(job_if.busy), 32'd0);
        check_eq("rst_done", 32'(job_if.done), 32'd0);
        check_eq("rst_ready", 32'(job_if.in_ready), 32'd0);
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic job: 2*3 + 4*5 + 10*10 = 126
        pb = '{8'd2, 8'd4, 8'd10, 8'd0};
        pc = '{8'd3, 8'd5, 8'd10, 8'd0};
        start_job(8'd3);
        check_eq("basic_busy", 32'(job_if.busy), 32'd1);
        feed(3, 0, accepted);
        check_eq("basic_accepted", 32'(accepted), 32'd3);
        finish_job("basic", 16'h007E, 1'b0, dcnt);
        check_eq("basic_done_count", 32'(dcnt), 32'd1);

        // Zero-length job goes straight to DONE and clears the previous result
        job_if.start = 1'b1;
        job_if.len   = 8'd0;
        @(negedge clk);
        check_eq("zero_ready_start", 32'(job_if.in_ready), 32'd0);
        @(posedge clk);
        #1;
        job_if.start = 1'b0;
        @(negedge clk);
        check_eq("zero_done", 32'(job_if.done), 32'd1);
        check_eq("zero_ready", 32'(job_if.in_ready), 32'd0);
        check_eq("zero_acc", 32'(job_if.acc), 32'd0);
        check_eq("zero_ovf", 32'(job_if.overflow), 32'd0);
        @(negedge clk);
        check_eq("zero_done_one_cycle", 32'(job_if.done), 32'd0);
        check_eq("zero_busy_after", 32'(job_if.busy), 32'd0);
        @(posedge clk);
        #1;

        // Stalled source, same pairs
        start_job(8'd3);
        feed(3, 3, accepted);
        check_eq("stall_accepted", 32'(accepted), 32'd3);
        finish_job("stall", 16'h007E, 1'b0, dcnt);

        // Overflow: 65025 + 65025 carries out of 16 bits
        pb = '{8'd255, 8'd255, 8'd1, 8'd0};
        pc = '{8'd255, 8'd255, 8'd1, 8'd0};
        start_job(8'd3);
        feed(3, 0, accepted);
        check_eq("ovf_accepted", 32'(accepted), 32'd3);
`ifdef MAC_SATURATE_EN
        finish_job("ovf", 16'hFFFF, 1'b1, dcnt);
`else
        finish_job("ovf", 16'h0000, 1'b1, dcnt);
`endif

        // Async reset mid-job
        start_job(8'd4);
        send_pair(8'd5, 8'd5, ok);
        check_eq("rstmid_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #2;
        check_eq("rstmid_pre_acc", 32'(job_if.acc), 32'h19);
        check_eq("rstmid_pre_ready", 32'(job_if.in_ready), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rstmid_acc", 32'(job_if.acc), 32'd0);
        check_eq("rstmid_ovf", 32'(job_if.overflow), 32'd0);
        check_eq("rstmid_busy", 32'(job_if.busy), 32'd0);
        check_eq("rstmid_ready", 32'(job_if.in_ready), 32'd0);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        start_job(8'd1);
        send_pair(8'd7, 8'd9, ok);
        check_eq("post_rst_accept", 32'(ok), 32'd1);
        finish_job("post_rst", 16'h003F, 1'b0, dcnt);

        // Start while busy is ignored
        start_job(8'd2);
        send_pair(8'd3, 8'd3, ok);
        job_if.start = 1'b1;
        job_if.len   = 8'd5;
        @(posedge clk);
        #1;
        job_if.start = 1'b0;
        check_eq("busy_start_still_busy", 32'(job_if.busy), 32'd1);
        send_pair(8'd1, 8'd1, ok);
        check_eq("busy_start_accept2", 32'(ok), 32'd1);
        finish_job("busy_start", 16'h000A, 1'b0, dcnt);
        check_eq("busy_start_done_count", 32'(dcnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
